mem_addr_unit: RTL and testbench
================================

# mem_addr_unit

Program-counter, data-address and memory-bus unit sitting directly downstream of the controller FSM. Consumes `load_pc`, `reset_pc`, `load_addr`, `addr_sel` and `mem_cmd`, and drives the synchronous instruction/data RAM. Returns one-cycle-latency read data (`mdata`) to the instruction register and to the datapath writeback mux. Also decodes a memory-mapped LED output register and switch input port, and flags illegal bus cycles.

## Interface
- `ADDR_W`, 9: word-address width; PC and data-address register width.
- `DATA_W`, 16: bus data width.
- `RAM_AW`, 8: RAM address width; RAM occupies addresses 0 to 2^RAM_AW-1.
- `LED_ADDR`, 9'h100: LED register write address.
- `SW_ADDR`, 9'h140: switch port read address.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `load_pc`  in  1  PC update strobe from controller.
- `reset_pc`  in  1  with `load_pc`, load PC with 0 instead of PC+1.
- `load_addr`  in  1  capture `datapath_out[ADDR_W-1:0]` into data-address register.
- `addr_sel`  in  1  1 selects PC as bus address; 0 selects data address.
- `mem_cmd`  in  2  00 none, 01 read, 10 write, 11 illegal.
- `datapath_out`  in  DATA_W  datapath C output: address source and write data.
- `ram_dout`  in  DATA_W  RAM synchronous read data.
- `sw`  in  8  switch inputs.
- `ram_addr`  out  RAM_AW  RAM address.
- `ram_din`  out  DATA_W  RAM write data (= `datapath_out`).
- `ram_we`  out  1  RAM write enable.
- `mdata`  out  DATA_W  read data to IR and writeback mux.
- `pc`  out  ADDR_W  current PC.
- `mem_addr`  out  ADDR_W  current bus address.
- `ledr`  out  8  LED register.
- `bus_err`  out  1  sticky illegal-access flag.

## Operation
- PC register:
  - `load_pc & reset_pc` → 0.
  - `load_pc & !reset_pc` → PC+1, wrapping modulo 2^ADDR_W (0x1FF → 0x000).
  - Otherwise hold.
- Data-address register: `load_addr` → `datapath_out[ADDR_W-1:0]` (upper bits discarded); otherwise hold.
- `mem_addr = addr_sel ? pc : data_addr`. Combinational, and uses pre-edge register values.
- Region decode on `mem_addr`:
  - RAM when `mem_addr[ADDR_W-1]==0`.
  - LED when equal to `LED_ADDR`.
  - SW when equal to `SW_ADDR`.
  - Everything else is unmapped.
- Write (`mem_cmd==10`):
  - RAM region → `ram_we=1` combinationally.
  - LED region → `ledr <= datapath_out[7:0]` at the edge.
  - SW or unmapped → no effect; set `bus_err`.
- Read (`mem_cmd==01`): a registered read-source tag (NONE/RAM/SW) captures the region at the edge; `sw` is sampled into `sw_q` on the same edge.
  - Tag RAM → `mdata = ram_dout`.
  - Tag SW → `mdata = {8'h00, sw_q}`.
  - Tag NONE → `mdata = 0`.
  - A read of LED or unmapped addresses returns 0 and sets `bus_err`.
- Tag holds while `mem_cmd==01` repeats. Any non-read cycle sets the tag to NONE on the next edge.
- `mem_cmd==11` → no RAM/LED effect, tag NONE, sets `bus_err`.
- `bus_err` is sticky and is cleared only by reset.

## Timing
- Reset (asynchronous assert, release on the next edge):
  - Registers: `pc=0`, `data_addr=0`, `ledr=0`, tag NONE, `sw_q=0`, `bus_err=0`.
  - Outputs: `mdata=0`, `ram_we=0` (no command present), `mem_addr=0`.
- Read latency is 1 cycle. Address with `mem_cmd=01` in cycle N gives valid `mdata` in cycle N+1. This matches a read issued in the fetch cycle and `load_ir` asserted in the following cycle.
- Write takes effect at the edge ending the cycle in which `mem_cmd=10`.
- Simultaneous events:
  - `load_pc` and `load_addr` in one cycle → both update.
  - `load_addr` with a read in the same cycle → the read uses the old data address.
  - `load_pc` during a PC-sourced read → the read uses the old PC.
- Reset mid-read: tag cleared, so `mdata=0` in the following cycle regardless of `ram_dout`.

## Configuration
- `MEM_ACCESS_COUNT_EN` defined adds outputs `fetch_cnt`, `load_cnt`, `store_cnt` (16 bits each). Each saturates at 0xFFFF and resets to 0.
  - `fetch_cnt` increments on a read with `addr_sel=1`.
  - `load_cnt` increments on a read with `addr_sel=0`.
  - `store_cnt` increments on any write command.
- Undefined: the ports still exist, are tied to 0, and no counter logic is generated.

## Test plan
- Reset then fetch: release reset; `load_pc=1,reset_pc=1` → `pc=0`. Read with `addr_sel=1`, RAM[0]=16'hD105 → `mdata=16'hD105` one cycle later. `load_pc` → `pc=1`.
- PC wrap: preset PC to 0x1FF, `load_pc=1` → `pc=0x000`.
- Load/store: `datapath_out=16'h0014`, `load_addr`. Write with `datapath_out=16'hABCD` → `ram_we=1`, `ram_addr=0x14`, RAM[0x14]=ABCD. Read back → `mdata=16'hABCD`.
- MMIO: `data_addr=0x100`, write `16'h00A5` → `ledr=8'hA5`, `ram_we=0`. Read `0x140` with `sw=8'h3C` → `mdata=16'h003C`.
- Errors: write to 0x180 → `bus_err=1`, `ledr` and RAM unchanged. Then `mem_cmd=11` → `bus_err` stays 1. Reset → `bus_err=0`.
- Reset mid-read: assert `reset` low in the read cycle → `mdata=0`, `pc=0`. With `MEM_ACCESS_COUNT_EN`, 3 fetches and 1 store give `fetch_cnt=3`, `store_cnt=1`.

Source files
------------

// File: rtl/mem_addr_unit.sv
// PC, data-address and memory-bus unit: RAM/LED/switch decode, 1-cycle read return, sticky bus error.
// Define MEM_ACCESS_COUNT_EN to build the saturating fetch/load/store access counters.
module mem_addr_unit #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned RAM_AW = 8,
  parameter logic [ADDR_W-1:0] LED_ADDR = 9'h100,
  parameter logic [ADDR_W-1:0] SW_ADDR  = 9'h140
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_pc,
  input  logic              reset_pc,
  input  logic              load_addr,
  input  logic              addr_sel,
  input  logic [1:0]        mem_cmd,
  input  logic [DATA_W-1:0] datapath_out,
  input  logic [DATA_W-1:0] ram_dout,
  input  logic [7:0]        sw,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_we,
  output logic [DATA_W-1:0] mdata,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        ledr,
  output logic              bus_err,
  output logic [15:0]       fetch_cnt,
  output logic [15:0]       load_cnt,
  output logic [15:0]       store_cnt
);

  localparam logic [1:0] CMD_NONE  = 2'b00;
  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;
  localparam logic [1:0] CMD_ILL   = 2'b11;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_RAM  = 2'd1,
    TAG_SW   = 2'd2
  } rd_tag_t;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] daddr_q, daddr_d;
  logic [7:0]        led_q, led_d;
  logic [7:0]        sw_q, sw_d;
  logic              err_q, err_d;
  rd_tag_t           tag_q, tag_d;
  logic              is_ram, is_led, is_sw;

  assign mem_addr = addr_sel ? pc_q : daddr_q;
  assign is_ram   = ~mem_addr[ADDR_W-1];
  assign is_led   = (mem_addr == LED_ADDR);
  assign is_sw    = (mem_addr == SW_ADDR);
  assign ram_addr = mem_addr[RAM_AW-1:0];
  assign ram_din  = datapath_out;
  assign ram_we   = (mem_cmd == CMD_WRITE) && is_ram;
  assign pc       = pc_q;
  assign ledr     = led_q;
  assign bus_err  = err_q;

  // Next-state for PC, data address, LED, switch sample, read tag and error flag
  always_comb begin
    pc_d    = pc_q;
    daddr_d = daddr_q;
    led_d   = led_q;
    sw_d    = sw_q;
    err_d   = err_q;
    tag_d   = TAG_NONE;
    if (load_pc) begin
      if (reset_pc) begin
        pc_d = {ADDR_W{1'b0}};
      end else begin
        pc_d = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
      end
    end else begin
      pc_d = pc_q;
    end
    if (load_addr) begin
      daddr_d = datapath_out[ADDR_W-1:0];
    end else begin
      daddr_d = daddr_q;
    end
    case (mem_cmd)
      CMD_READ: begin
        sw_d = sw;
        if (is_ram) begin
          tag_d = TAG_RAM;
        end else if (is_sw) begin
          tag_d = TAG_SW;
        end else begin
          tag_d = TAG_NONE;
          err_d = 1'b1;
        end
      end
      CMD_WRITE: begin
        if (is_led) begin
          led_d = datapath_out[7:0];
        end else if (!is_ram) begin
          err_d = 1'b1;
        end else begin
          led_d = led_q;
        end
      end
      CMD_ILL:  err_d = 1'b1;
      CMD_NONE: tag_d = TAG_NONE;
      default:  tag_d = TAG_NONE;
    endcase
  end

  // State registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q    <= {ADDR_W{1'b0}};
      daddr_q <= {ADDR_W{1'b0}};
      led_q   <= 8'h00;
      sw_q    <= 8'h00;
      err_q   <= 1'b0;
      tag_q   <= TAG_NONE;
    end else begin
      pc_q    <= pc_d;
      daddr_q <= daddr_d;
      led_q   <= led_d;
      sw_q    <= sw_d;
      err_q   <= err_d;
      tag_q   <= tag_d;
    end
  end

  // Read-return mux steered by the tag captured on the read edge
  always_comb begin
    case (tag_q)
      TAG_RAM:  mdata = ram_dout;
      TAG_SW:   mdata = {{(DATA_W-8){1'b0}}, sw_q};
      TAG_NONE: mdata = {DATA_W{1'b0}};
      default:  mdata = {DATA_W{1'b0}};
    endcase
  end

`ifdef MEM_ACCESS_COUNT_EN
  logic [15:0] fetch_q, load_q, store_q;
  logic        rd_cyc, wr_cyc;

  assign rd_cyc    = (mem_cmd == CMD_READ);
  assign wr_cyc    = (mem_cmd == CMD_WRITE);
  assign fetch_cnt = fetch_q;
  assign load_cnt  = load_q;
  assign store_cnt = store_q;

  // Saturating access counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_q <= 16'h0000;
      load_q  <= 16'h0000;
      store_q <= 16'h0000;
    end else begin
      if (rd_cyc && addr_sel && (fetch_q != 16'hFFFF)) begin
        fetch_q <= fetch_q + 16'd1;
      end
      if (rd_cyc && !addr_sel && (load_q != 16'hFFFF)) begin
        load_q <= load_q + 16'd1;
      end
      if (wr_cyc && (store_q != 16'hFFFF)) begin
        store_q <= store_q + 16'd1;
      end
    end
  end
`else
  assign fetch_cnt = 16'h0000;
  assign load_cnt  = 16'h0000;
  assign store_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_mem_addr_unit.sv
// Directed bench for mem_addr_unit with a behavioural synchronous 256x16 RAM attached.
module tb_mem_addr_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        load_pc, reset_pc, load_addr, addr_sel;
  logic [1:0]  mem_cmd;
  logic [15:0] datapath_out, ram_dout;
  logic [7:0]  sw;
  logic [7:0]  ram_addr;
  logic [15:0] ram_din;
  logic        ram_we;
  logic [15:0] mdata;
  logic [8:0]  pc, mem_addr;
  logic [7:0]  ledr;
  logic        bus_err;
  logic [15:0] fetch_cnt, load_cnt, store_cnt;

  int total = 0;
  int bad   = 0;

  logic [15:0] ram [0:255];
  logic        ram_init;
  logic [7:0]  init_idx = 8'd0;

  mem_addr_unit dut (
    .clk(clk), .reset(reset), .load_pc(load_pc), .reset_pc(reset_pc),
    .load_addr(load_addr), .addr_sel(addr_sel), .mem_cmd(mem_cmd),
    .datapath_out(datapath_out), .ram_dout(ram_dout), .sw(sw),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .mdata(mdata),
    .pc(pc), .mem_addr(mem_addr), .ledr(ledr), .bus_err(bus_err),
    .fetch_cnt(fetch_cnt), .load_cnt(load_cnt), .store_cnt(store_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] init_val(input logic [7:0] a);
    case (a)
      8'h00:   return 16'hD105;
      8'h02:   return 16'h5A5A;
      default: return 16'h0000;
    endcase
  endfunction

  // Synchronous RAM model, preloaded while ram_init is high
  always @(posedge clk) begin
    if (ram_init) begin
      ram[init_idx] <= init_val(init_idx);
      init_idx      <= init_idx + 8'd1;
    end else if (ram_we) begin
      ram[ram_addr] <= ram_din;
    end
    ram_dout <= ram[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    ram_init = 1'b1;
    reset = 1'b0;
    load_pc = 1'b0; reset_pc = 1'b0; load_addr = 1'b0; addr_sel = 1'b0;
    mem_cmd = 2'b00; datapath_out = 16'h0000; sw = 8'h00;
    repeat (258) cyc();
    ram_init = 1'b0;
    chk("rst_pc", pc, 9'h000);
    chk("rst_mem_addr", mem_addr, 9'h000);
    chk("rst_mdata", mdata, 16'h0000);
    chk("rst_ram_we", ram_we, 1'b0);
    chk("rst_ledr", ledr, 8'h00);
    chk("rst_bus_err", bus_err, 1'b0);
    reset = 1'b1;
    cyc();

    // reset then fetch
    load_pc = 1'b1; reset_pc = 1'b1; cyc();
    load_pc = 1'b0; reset_pc = 1'b0;
    chk("pc_reset", pc, 9'h000);
    addr_sel = 1'b1; mem_cmd = 2'b01; cyc();
    mem_cmd = 2'b00;
    chk("fetch_mdata", mdata, 16'hD105);
    load_pc = 1'b1; cyc();
    chk("pc_inc", pc, 9'h001);

    // walk PC to 0x1FF then wrap
    repeat (510) cyc();
    chk("pc_1ff", pc, 9'h1FF);
    cyc();
    load_pc = 1'b0;
    chk("pc_wrap", pc, 9'h000);

    // load_pc during a PC-sourced read uses the old PC
    load_pc = 1'b1; mem_cmd = 2'b01; cyc();
    load_pc = 1'b0; mem_cmd = 2'b00;
    chk("fetch_old_pc", mdata, 16'hD105);
    chk("pc_after_fetch", pc, 9'h001);

    // load / store
    addr_sel = 1'b0; datapath_out = 16'h0014; load_addr = 1'b1; cyc();
    load_addr = 1'b0;
    chk("daddr_load", mem_addr, 9'h014);
    datapath_out = 16'hABCD; mem_cmd = 2'b10; #1;
    chk("st_ram_we", ram_we, 1'b1);
    chk("st_ram_addr", ram_addr, 8'h14);
    cyc();
    mem_cmd = 2'b00;
    chk("st_ram_data", ram[8'h14], 16'hABCD);
    mem_cmd = 2'b01; cyc();
    mem_cmd = 2'b00;
    chk("ld_mdata", mdata, 16'hABCD);

    // load_addr together with a read: read uses old data address
    datapath_out = 16'h0100; load_addr = 1'b1; mem_cmd = 2'b01; cyc();
    load_addr = 1'b0; mem_cmd = 2'b00;
    chk("ld_old_addr", mdata, 16'hABCD);
    chk("daddr_new", mem_addr, 9'h100);

    // MMIO
    datapath_out = 16'h00A5; mem_cmd = 2'b10; #1;
    chk("led_ram_we", ram_we, 1'b0);
    cyc();
    mem_cmd = 2'b00;
    chk("ledr_write", ledr, 8'hA5);
    datapath_out = 16'h0140; load_addr = 1'b1; cyc();
    load_addr = 1'b0;
    sw = 8'h3C; mem_cmd = 2'b01; cyc();
    mem_cmd = 2'b00; sw = 8'h00;
    chk("sw_read", mdata, 16'h003C);
    cyc();
    chk("tag_none", mdata, 16'h0000);
    chk("no_err_yet", bus_err, 1'b0);

    // errors
    datapath_out = 16'h0180; load_addr = 1'b1; cyc();
    load_addr = 1'b0;
    datapath_out = 16'h1234; mem_cmd = 2'b10; #1;
    chk("unmapped_we", ram_we, 1'b0);
    cyc();
    mem_cmd = 2'b00;
    chk("err_set", bus_err, 1'b1);
    chk("err_ledr", ledr, 8'hA5);
    chk("err_ram", ram[8'h80], 16'h0000);
    mem_cmd = 2'b11; cyc();
    mem_cmd = 2'b00;
    chk("err_sticky", bus_err, 1'b1);
    reset = 1'b0; #1;
    chk("err_clr", bus_err, 1'b0);
    chk("ledr_clr", ledr, 8'h00);
    cyc();
    reset = 1'b1;
    cyc();

    // reset in the middle of a read
    addr_sel = 1'b1; load_pc = 1'b1; cyc(); cyc();
    load_pc = 1'b0;
    chk("pc_two", pc, 9'h002);
    mem_cmd = 2'b01; #2;
    reset = 1'b0;
    cyc();
    chk("rst_read_mdata", mdata, 16'h0000);
    chk("rst_read_pc", pc, 9'h000);
    mem_cmd = 2'b00; reset = 1'b1;
    cyc();

    // three fetches then one store
    mem_cmd = 2'b01; cyc();
    chk("rep_fetch1", mdata, 16'hD105);
    cyc();
    chk("rep_fetch2", mdata, 16'hD105);
    cyc();
    addr_sel = 1'b0; datapath_out = 16'hD105; mem_cmd = 2'b10; cyc();
    mem_cmd = 2'b00;
`ifdef MEM_ACCESS_COUNT_EN
    chk("fetch_cnt", fetch_cnt, 16'd3);
    chk("load_cnt", load_cnt, 16'd0);
    chk("store_cnt", store_cnt, 16'd1);
`else
    chk("fetch_cnt", fetch_cnt, 16'd0);
    chk("load_cnt", load_cnt, 16'd0);
    chk("store_cnt", store_cnt, 16'd0);
`endif
    chk("store_ram0", ram[8'h00], 16'hD105);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
